// File: rtl/sol32_pkg.sv
// Shared types and default widths for the sol32 fetch front end.
package sol32_pkg;

    localparam int SOL32_ADDR_WIDTH = 32;
    localparam int SOL32_DATA_WIDTH = 32;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sol32_fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head word is read straight from storage.
module sol32_fetch_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Callers guarantee no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= data_in;
    end

    assign data_out = mem[rd_ptr];

endmodule

// File: rtl/sol32_fetch_unit.sv
// Credit-limited instruction fetch unit with prefetch queue and redirect flush.
// Optional SOL32_FETCH_HALT_EN adds a Halt input that suppresses new requests.
module sol32_fetch_unit
    import sol32_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = SOL32_ADDR_WIDTH,
    parameter int                    DATA_WIDTH    = SOL32_DATA_WIDTH,
    parameter int                    DEPTH         = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
`ifdef SOL32_FETCH_HALT_EN
    input  logic                  Halt,
`endif
    output logic                  FetchRequest,
    output logic [ADDR_WIDTH-1:0] FetchAddress,
    input  logic                  FetchAccept,
    input  logic                  InstructionReady,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectAddress,
    output logic                  DecodeValid,
    output logic [DATA_WIDTH-1:0] DecodeInstruction,
    output logic [ADDR_WIDTH-1:0] DecodeAddress,
    input  logic                  DecodeReady
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t                      state;
    logic [ADDR_WIDTH-1:0]             pc;
    logic [CNT_W-1:0]                  occupancy;
    logic [CNT_W-1:0]                  outstanding;
    logic [CNT_W-1:0]                  outstanding_next;
    logic [CNT_W-1:0]                  stale_count;
    logic                              halt;
    logic                              credit;
    logic                              accept;
    logic                              response;
    logic                              live;
    logic [ADDR_WIDTH-1:0]             resp_addr;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0]  head;

`ifdef SOL32_FETCH_HALT_EN
    assign halt = Halt;
`else
    assign halt = 1'b0;
`endif

    // Queue slots are reserved at request time, so a live response always has room.
    assign credit = ({1'b0, occupancy} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);

    assign FetchRequest     = !Reset && (state == RUN) && credit && !Redirect && !halt;
    assign FetchAddress     = pc;
    assign accept           = FetchRequest && FetchAccept;
    assign response         = InstructionReady && (outstanding != '0);
    assign live             = response && (stale_count == '0);
    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(response);

    sol32_fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) inflight_fifo (
        .clk      (Clock),
        .rst      (Reset),
        .push     (accept),
        .pop      (response),
        .flush    (1'b0),
        .data_in  (pc),
        .data_out (resp_addr),
        .count    (outstanding)
    );

    sol32_fetch_fifo #(
        .WIDTH (DATA_WIDTH + ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) queue_fifo (
        .clk      (Clock),
        .rst      (Reset),
        .push     (live && !Redirect),
        .pop      (DecodeValid && DecodeReady && !Redirect),
        .flush    (Redirect),
        .data_in  ({Instruction, resp_addr}),
        .data_out (head),
        .count    (occupancy)
    );

    assign DecodeValid       = (occupancy != '0);
    assign DecodeInstruction = DecodeValid ? head[ADDR_WIDTH +: DATA_WIDTH] : '0;
    assign DecodeAddress     = DecodeValid ? head[ADDR_WIDTH-1:0] : '0;

    // Everything still in flight at a redirect belongs to the old stream.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= RUN;
            pc          <= RESET_ADDRESS;
            stale_count <= '0;
        end else if (Redirect) begin
            pc          <= RedirectAddress;
            stale_count <= outstanding_next;
            state       <= (outstanding_next != '0) ? DRAIN : RUN;
        end else begin
            if (accept)
                pc <= pc + 1'b1;
            if (response && (stale_count != '0))
                stale_count <= stale_count - 1'b1;
            if ((state == DRAIN) && (stale_count == '0))
                state <= RUN;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is a memory-side protocol violation.
    protocol_no_orphan_response: assert property (
        @(posedge Clock) disable iff (Reset) !(InstructionReady && (outstanding == '0))
    );
`endif

endmodule

// File: tb/tb_sol32_fetch_unit.sv
// Directed bench for sol32_fetch_unit with a fixed-latency in-order memory model.
module tb_sol32_fetch_unit;

    logic        clk;
    logic        Reset;
    logic        FetchRequest;
    logic [31:0] FetchAddress;
    logic        FetchAccept;
    logic        InstructionReady;
    logic [31:0] Instruction;
    logic        Redirect;
    logic [31:0] RedirectAddress;
    logic        DecodeValid;
    logic [31:0] DecodeInstruction;
    logic [31:0] DecodeAddress;
    logic        DecodeReady;
`ifdef SOL32_FETCH_HALT_EN
    logic        Halt;
`endif

    sol32_fetch_unit dut (
        .Clock             (clk),
        .Reset             (Reset),
`ifdef SOL32_FETCH_HALT_EN
        .Halt              (Halt),
`endif
        .FetchRequest      (FetchRequest),
        .FetchAddress      (FetchAddress),
        .FetchAccept       (FetchAccept),
        .InstructionReady  (InstructionReady),
        .Instruction       (Instruction),
        .Redirect          (Redirect),
        .RedirectAddress   (RedirectAddress),
        .DecodeValid       (DecodeValid),
        .DecodeInstruction (DecodeInstruction),
        .DecodeAddress     (DecodeAddress),
        .DecodeReady       (DecodeReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    int          lat   = 1;
    int          reqs  = 0;
    int          ndec  = 0;
    logic [31:0] next_dec = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present the due response, sample request/decode, advance.
    task automatic step();
        if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            InstructionReady = 1'b1;
            Instruction      = instr_of(mq[0].a);
            void'(mq.pop_front());
        end else begin
            InstructionReady = 1'b0;
            Instruction      = '0;
        end
        #2;
        if (FetchRequest && FetchAccept) begin
            mq.push_back('{FetchAddress, cyc_n + lat});
            reqs++;
        end
        if (!Reset && DecodeValid && DecodeReady) begin
            chk("dec_addr", DecodeAddress, next_dec);
            chk("dec_instr", DecodeInstruction, instr_of(next_dec));
            next_dec = next_dec + 32'd1;
            ndec++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        FetchAccept = 1'b0;
        Redirect    = 1'b0;
        DecodeReady = 1'b0;
`ifdef SOL32_FETCH_HALT_EN
        Halt        = 1'b0;
`endif
        mq.delete();
        step();
        chk("rst_req", FetchRequest, 0);
        chk("rst_dvalid", DecodeValid, 0);
        chk("rst_dinstr", DecodeInstruction, 0);
        chk("rst_daddr", DecodeAddress, 0);
        step();
        Reset    = 1'b0;
        next_dec = '0;
        #1;
    endtask

    task automatic wait_request(input string tag);
        int k = 0;
        while (!FetchRequest && k < 12) begin
            step();
            k++;
        end
        chk(tag, FetchRequest, 1);
    endtask

    initial begin
        Reset            = 1'b1;
        FetchAccept      = 1'b0;
        InstructionReady = 1'b0;
        Instruction      = '0;
        Redirect         = 1'b0;
        RedirectAddress  = '0;
        DecodeReady      = 1'b0;
`ifdef SOL32_FETCH_HALT_EN
        Halt             = 1'b0;
`endif
        @(negedge clk);

        // Sequential stream, latency 1, decode always ready.
        lat = 1;
        do_reset();
        chk("start_req", FetchRequest, 1);
        chk("start_addr", FetchAddress, 0);
        FetchAccept = 1'b1;
        DecodeReady = 1'b1;
        ndec = 0;
        repeat (12) step();
        chk("t1_ndec", ndec, 10);

        // Decode stalled: credit limit stops at DEPTH requests.
        do_reset();
        FetchAccept = 1'b1;
        DecodeReady = 1'b0;
        reqs = 0;
        repeat (8) step();
        chk("t2_reqs", reqs, 4);
        chk("t2_hold", FetchRequest, 0);
        chk("t2_head_v", DecodeValid, 1);
        chk("t2_head_a", DecodeAddress, 0);
        DecodeReady = 1'b1;
        ndec = 0;
        step();
        chk("t2_resume_req", FetchRequest, 1);
        chk("t2_resume_addr", FetchAddress, 4);
        repeat (8) step();
        chk("t2_ndec", ndec, 9);

        // Redirect with two requests in flight, latency 3.
        do_reset();
        lat = 3;
        FetchAccept = 1'b1;
        DecodeReady = 1'b1;
        step();
        step();
        Redirect        = 1'b1;
        RedirectAddress = 32'h0000_0100;
        next_dec        = 32'h0000_0100;
        ndec            = 0;
        #1;
        chk("t3_req_during_redirect", FetchRequest, 0);
        step();
        Redirect = 1'b0;
        #1;
        chk("t3_drain_a", FetchRequest, 0);
        step();
        chk("t3_drain_b", FetchRequest, 0);
        wait_request("t3_resume");
        chk("t3_resume_addr", FetchAddress, 32'h0000_0100);
        repeat (10) step();
        chk("t3_decoded", ndec > 0, 1);

        // PC wrap past all-ones.
        do_reset();
        lat = 1;
        FetchAccept     = 1'b0;
        DecodeReady     = 1'b1;
        Redirect        = 1'b1;
        RedirectAddress = 32'hFFFF_FFFE;
        next_dec        = 32'hFFFF_FFFE;
        ndec            = 0;
        step();
        Redirect = 1'b0;
        #1;
        chk("t4_req_next", FetchRequest, 1);
        chk("t4_addr_next", FetchAddress, 32'hFFFF_FFFE);
        FetchAccept = 1'b1;
        step();
        step();
        chk("t4_wrap", FetchAddress, 32'h0000_0000);
        repeat (6) step();
        chk("t4_ndec", ndec, 6);

        // Redirect coinciding with a live response, latency 2.
        do_reset();
        lat = 2;
        FetchAccept = 1'b1;
        DecodeReady = 1'b1;
        step();
        step();
        Redirect        = 1'b1;
        RedirectAddress = 32'h0000_0200;
        next_dec        = 32'h0000_0200;
        ndec            = 0;
        step();
        Redirect = 1'b0;
        #1;
        chk("t5_queue_empty", DecodeValid, 0);
        wait_request("t5_resume");
        chk("t5_resume_addr", FetchAddress, 32'h0000_0200);
        repeat (8) step();
        chk("t5_decoded", ndec > 0, 1);

`ifdef SOL32_FETCH_HALT_EN
        // Halt blocks requests while the queue keeps draining.
        do_reset();
        lat = 1;
        FetchAccept = 1'b1;
        DecodeReady = 1'b0;
        repeat (3) step();
        Halt        = 1'b1;
        DecodeReady = 1'b1;
        ndec        = 0;
        reqs        = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_halt_req", FetchRequest, 0);
            step();
        end
        chk("t6_reqs", reqs, 0);
        chk("t6_ndec", ndec, 3);
        Halt = 1'b0;
        #1;
        chk("t6_resume_req", FetchRequest, 1);
        chk("t6_resume_addr", FetchAddress, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
